// File: rtl/compuertas_pkg.sv
// Shared definitions for compuertas_sweep: gate function codes and sweep FSM states.
package compuertas_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/compuertas_sweep_gate_eval.sv
// gate_eval: combinational N_IN-input reducing gate; the function is chosen by op.
module gate_eval
  import compuertas_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0] x,
  input  logic [2:0]      op,
  output logic            y
);

  // NOTE: y gets a default before the case so no path through this block infers a latch.
  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = &x;
      OP_OR:   y = |x;
      OP_XOR:  y = ^x;
      OP_NAND: y = ~&x;
      OP_NOR:  y = ~|x;
      OP_XNOR: y = ~^x;
      default: y = 1'b0;  // reserved codes 6 and 7
    endcase
  end

endmodule

// File: rtl/compuertas_sweep.sv
// compuertas_sweep: two selectable N_IN-input gates with a registered direct mode and a
// truth-table sweep mode. Define COMPUERTAS_SWEEP_POPCOUNT_EN to add ones_s1/ones_s2 counters.
module compuertas_sweep
  import compuertas_pkg::*;
#(
  parameter  int N_IN = 3,
  localparam int TT_W = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in_vec,
  input  logic            in_valid,
  input  logic [2:0]      op1,
  input  logic [2:0]      op2,
  input  logic            start,
  output logic            S1,
  output logic            S2,
  output logic            out_valid,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt_s1,
  output logic [TT_W-1:0] tt_s2
`ifdef COMPUERTAS_SWEEP_POPCOUNT_EN
  ,
  output logic [N_IN:0]   ones_s1,
  output logic [N_IN:0]   ones_s2
`endif
);

  localparam logic [N_IN:0] IDX_LAST = (N_IN + 1)'(TT_W - 1);

  state_t          state_q, state_d;
  logic [N_IN:0]   idx_q;
  logic [2:0]      op1_q, op2_q;
  logic            s1_q, s2_q, out_valid_q;
  logic [TT_W-1:0] tt_s1_q, tt_s2_q;

  logic [N_IN-1:0] eval_in;
  logic [2:0]      eval_op1, eval_op2;
  logic            y1, y2;
  logic            in_sweep;

  assign in_sweep = (state_q == SWEEP);

  // During a sweep the gates see the index and the ops captured at start, not the live inputs.
  assign eval_in  = in_sweep ? idx_q[N_IN-1:0] : in_vec;
  assign eval_op1 = in_sweep ? op1_q : op1;
  assign eval_op2 = in_sweep ? op2_q : op2;

  gate_eval #(.N_IN(N_IN)) u_gate_s1 (.x(eval_in), .op(eval_op1), .y(y1));
  gate_eval #(.N_IN(N_IN)) u_gate_s2 (.x(eval_in), .op(eval_op2), .y(y2));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SWEEP;
      SWEEP:   if (idx_q == IDX_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      tt_s1_q     <= '0;
      tt_s2_q     <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // start outranks in_valid: the direct request in the same cycle is dropped.
            idx_q   <= '0;
            op1_q   <= op1;
            op2_q   <= op2;
            tt_s1_q <= '0;
            tt_s2_q <= '0;
          end else if (in_valid) begin
            s1_q        <= y1;
            s2_q        <= y2;
            out_valid_q <= 1'b1;
          end
        end
        SWEEP: begin
          tt_s1_q[idx_q[N_IN-1:0]] <= y1;
          tt_s2_q[idx_q[N_IN-1:0]] <= y2;
          idx_q                    <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef COMPUERTAS_SWEEP_POPCOUNT_EN
  logic [N_IN:0] ones_s1_q, ones_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_s1_q <= '0;
      ones_s2_q <= '0;
    end else if (state_q == IDLE && start) begin
      ones_s1_q <= '0;
      ones_s2_q <= '0;
    end else if (in_sweep) begin
      ones_s1_q <= ones_s1_q + {{N_IN{1'b0}}, y1};
      ones_s2_q <= ones_s2_q + {{N_IN{1'b0}}, y2};
    end
  end

  assign ones_s1 = ones_s1_q;
  assign ones_s2 = ones_s2_q;
`endif

  assign S1        = s1_q;
  assign S2        = s2_q;
  assign out_valid = out_valid_q;
  assign busy      = in_sweep;
  assign done      = (state_q == DONE);
  assign tt_s1     = tt_s1_q;
  assign tt_s2     = tt_s2_q;

endmodule

// File: tb/tb_compuertas_sweep.sv
// Directed self-checking bench for compuertas_sweep (N_IN=3): direct mode, sweeps,
// ignored requests during a sweep, asynchronous abort and reserved op codes.
module tb_compuertas_sweep;

  localparam int N_IN = 3;
  localparam int TT_W = 2 ** N_IN;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_IN-1:0] in_vec;
  logic            in_valid;
  logic [2:0]      op1, op2;
  logic            start;
  logic            S1, S2, out_valid, busy, done;
  logic [TT_W-1:0] tt_s1, tt_s2;
`ifdef COMPUERTAS_SWEEP_POPCOUNT_EN
  logic [N_IN:0]   ones_s1, ones_s2;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  compuertas_sweep #(.N_IN(N_IN)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vec   (in_vec),
    .in_valid (in_valid),
    .op1      (op1),
    .op2      (op2),
    .start    (start),
    .S1       (S1),
    .S2       (S2),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done),
    .tt_s1    (tt_s1),
    .tt_s2    (tt_s2)
`ifdef COMPUERTAS_SWEEP_POPCOUNT_EN
    ,
    .ones_s1  (ones_s1),
    .ones_s2  (ones_s2)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full sweep with ops scrambled while it runs; checks length, done pulse and tables.
  task automatic do_sweep(input string tag, input logic [2:0] o1, input logic [2:0] o2,
                          input logic [7:0] e1, input logic [7:0] e2);
    int busy_cnt;
    op1   = o1;
    op2   = o2;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " tt_s1 cleared"}, 32'(tt_s1), 32'h0);
    check({tag, " tt_s2 cleared"}, 32'(tt_s2), 32'h0);
    busy_cnt = 0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      op1 = 3'(cyc);
      op2 = 3'(cyc + 3);
      if (busy) busy_cnt++;
      step();
    end
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'd8);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy in DONE"}, 32'(busy), 32'd0);
    check({tag, " tt_s1"}, 32'(tt_s1), 32'(e1));
    check({tag, " tt_s2"}, 32'(tt_s2), 32'(e2));
    step();
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    check({tag, " tt_s1 hold"}, 32'(tt_s1), 32'(e1));
  endtask

  initial begin
    int wait_cnt;
    rst      = 1'b1;
    in_vec   = '0;
    in_valid = 1'b0;
    op1      = 3'd0;
    op2      = 3'd0;
    start    = 1'b0;
    step();
    step();

    // Reset state
    check("rst S1", 32'(S1), 32'd0);
    check("rst S2", 32'(S2), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst tt_s1", 32'(tt_s1), 32'h0);
    check("rst tt_s2", 32'(tt_s2), 32'h0);
    rst = 1'b0;
    step();

    // Direct mode: AND/OR of 101, then 111
    in_vec = 3'b101; op1 = 3'd0; op2 = 3'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("direct101 S1", 32'(S1), 32'd0);
    check("direct101 S2", 32'(S2), 32'd1);
    check("direct101 out_valid", 32'(out_valid), 32'd1);
    step();
    check("direct101 out_valid pulse", 32'(out_valid), 32'd0);
    check("direct101 S2 hold", 32'(S2), 32'd1);
    in_vec = 3'b111; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("direct111 S1", 32'(S1), 32'd1);
    check("direct111 S2", 32'(S2), 32'd1);
    check("direct111 out_valid", 32'(out_valid), 32'd1);
    step();

    // Sweeps with scrambled ops mid-sweep
    do_sweep("and_or", 3'd0, 3'd1, 8'h80, 8'hFE);
`ifdef COMPUERTAS_SWEEP_POPCOUNT_EN
    check("pop ones_s1", 32'(ones_s1), 32'd1);
    check("pop ones_s2", 32'(ones_s2), 32'd7);
`endif
    do_sweep("xor_xnor", 3'd2, 3'd5, 8'h96, 8'h69);
    do_sweep("nand_nor", 3'd3, 3'd4, 8'h7F, 8'h01);
    check("S1 held across sweeps", 32'(S1), 32'd1);

    // start + in_valid at idx=3 are ignored
    op1 = 3'd0; op2 = 3'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    in_vec = 3'b000; start = 1'b1; in_valid = 1'b1; op1 = 3'd4; op2 = 3'd4;
    step();
    start = 1'b0; in_valid = 1'b0;
    check("midsweep out_valid", 32'(out_valid), 32'd0);
    check("midsweep busy", 32'(busy), 32'd1);
    wait_cnt = 0;
    while (!done && wait_cnt < 20) begin
      step();
      wait_cnt++;
    end
    check("midsweep remaining cycles", 32'(wait_cnt), 32'd4);
    check("midsweep tt_s1", 32'(tt_s1), 32'h80);
    check("midsweep tt_s2", 32'(tt_s2), 32'hFE);
    check("midsweep S1 hold", 32'(S1), 32'd1);
    step();

    // start and in_valid together in IDLE: sweep wins
    in_vec = 3'b000; op1 = 3'd2; op2 = 3'd5; start = 1'b1; in_valid = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b0;
    check("tie out_valid", 32'(out_valid), 32'd0);
    check("tie busy", 32'(busy), 32'd1);
    check("tie S1 unchanged", 32'(S1), 32'd1);
    wait_cnt = 0;
    while (!done && wait_cnt < 20) begin
      step();
      wait_cnt++;
    end
    check("tie done", 32'(done), 32'd1);
    check("tie tt_s1", 32'(tt_s1), 32'h96);
    check("tie tt_s2", 32'(tt_s2), 32'h69);
    step();

    // Asynchronous reset at idx=5 aborts the sweep
    op1 = 3'd1; op2 = 3'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step(); step();
    check("abort busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort tt_s1", 32'(tt_s1), 32'h0);
    check("abort tt_s2", 32'(tt_s2), 32'h0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort S1", 32'(S1), 32'd0);
    check("abort done", 32'(done), 32'd0);
    step();
    check("abort no done", 32'(done), 32'd0);
    rst = 1'b0;
    step();
    check("abort idle no done", 32'(done), 32'd0);
    do_sweep("after_abort", 3'd2, 3'd5, 8'h96, 8'h69);

    // Reserved op codes produce 0
    do_sweep("reserved", 3'd6, 3'd7, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
